// File: rtl/processador_parametrizado_if.sv
// Control/load/status bundle for processador_parametrizado.
// The master side loads memory and pulses start/step; the slave side is the core.
interface processador_parametrizado_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              step;
  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] pc;
  logic              carry;
  logic [DATA_W-1:0] out_port;
  logic              busy;
  logic              halted;

  modport master (
    output start, load_en, load_addr, load_data, step,
    input  acc, pc, carry, out_port, busy, halted
  );

  modport slave (
    input  start, load_en, load_addr, load_data, step,
    output acc, pc, carry, out_port, busy, halted
  );
endinterface

// File: rtl/processador_parametrizado.sv
// Accumulator CPU, 3 cycles per instruction (FETCH/DECODE/EXEC), 2^ADDR_W-word memory.
// Define PROCESSADOR_STEP_EN to park in WAIT after each instruction until a step pulse.
module processador_parametrizado #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic clock,
  input  logic reset,
  processador_parametrizado_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int IR_W  = 4 + ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
`ifdef PROCESSADOR_STEP_EN
    , S_WAIT
`endif
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [IR_W-1:0]   ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic              busy_q, halted_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              idle_like;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign opcode    = ir_q[IR_W-1:ADDR_W];
  assign operand   = ir_q[ADDR_W-1:0];
  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);

`ifndef PROCESSADOR_STEP_EN
  logic unused_step;
  assign unused_step = bus.step;
`endif

  // Loader and STA share one write port; they can never collide since
  // loading is only honoured outside of execution.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.load_addr;
    mem_wdata = bus.load_data;
    if (idle_like && bus.load_en) begin
      mem_we = 1'b1;
    end else if (state_q == S_EXEC && opcode == 4'h2) begin
      mem_we    = 1'b1;
      mem_waddr = operand;
      mem_wdata = acc_q;
    end
  end

  // Memory is deliberately outside the reset domain so programs survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // EXEC datapath result
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    pc_d    = pc_q;
    out_d   = out_q;
    case (opcode)
      4'h1: acc_d = mdr_q;
      4'h3: {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, mdr_q};
      4'h4: {carry_d, acc_d} = {1'b0, acc_q} - {1'b0, mdr_q};
      4'h5: acc_d = acc_q & mdr_q;
      4'h6: acc_d = acc_q | mdr_q;
      4'h7: acc_d = acc_q ^ mdr_q;
      4'h8: acc_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
      4'h9: pc_d  = operand;
      4'hA: if (acc_q == '0) pc_d = operand;
      4'hB: if (carry_q)     pc_d = operand;
      4'hC: acc_d = ~acc_q;
      4'hD: {carry_d, acc_d} = {acc_q, 1'b0};
      4'hE: out_d = acc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      pc_q     <= '0;
      carry_q  <= 1'b0;
      out_q    <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_q    <= mem_q[pc_q][IR_W-1:0];
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          mdr_q   <= mem_q[operand];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          pc_q    <= pc_d;
          out_q   <= out_d;
          if (opcode == 4'hF) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
`ifdef PROCESSADOR_STEP_EN
            state_q <= S_WAIT;
`else
            state_q <= S_FETCH;
`endif
          end
        end
`ifdef PROCESSADOR_STEP_EN
        S_WAIT: if (bus.step) state_q <= S_FETCH;
`endif
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc      = acc_q;
  assign bus.pc       = pc_q;
  assign bus.carry    = carry_q;
  assign bus.out_port = out_q;
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_processador_parametrizado.sv
// Bench for processador_parametrizado (default build): instruction-level model,
// per-cycle output compare, directed programs plus randomized programs/loads/resets.
module tb_processador_parametrizado;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  processador_parametrizado_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  processador_parametrizado #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // architectural model: one instruction executes atomically at the end of its 3rd cycle
  logic [7:0] m_mem [16];
  logic [7:0] m_acc, m_out;
  logic [3:0] m_pc;
  logic       m_carry;
  bit         m_run, m_halt;
  int         m_phase;
  logic [7:0] prog [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_exec();
    logic [7:0] ir, mdr;
    logic [3:0] opd;
    int sum;
    ir  = m_mem[m_pc];
    opd = ir[3:0];
    m_pc = m_pc + 4'd1;
    mdr = m_mem[opd];
    case (ir[7:4])
      4'h1: m_acc = mdr;
      4'h2: m_mem[opd] = m_acc;
      4'h3: begin sum = int'(m_acc) + int'(mdr); m_carry = (sum > 255); m_acc = 8'(sum % 256); end
      4'h4: begin m_carry = (m_acc < mdr); m_acc = 8'((int'(m_acc) - int'(mdr) + 256) % 256); end
      4'h5: m_acc = m_acc & mdr;
      4'h6: m_acc = m_acc | mdr;
      4'h7: m_acc = m_acc ^ mdr;
      4'h8: m_acc = 8'(opd);
      4'h9: m_pc = opd;
      4'hA: if (m_acc == 8'd0) m_pc = opd;
      4'hB: if (m_carry) m_pc = opd;
      4'hC: m_acc = 8'(255 - int'(m_acc));
      4'hD: begin m_carry = (m_acc >= 8'd128); m_acc = 8'((int'(m_acc) * 2) % 256); end
      4'hE: m_out = m_acc;
      4'hF: begin m_run = 0; m_halt = 1; end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
      if (bus.start) begin
        m_run = 1; m_halt = 0; m_phase = 0;
        m_pc = 4'd0; m_acc = 8'd0; m_carry = 1'b0;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
      model_exec();
    end else begin
      m_phase++;
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_phase = 0;
    m_pc = 4'd0; m_acc = 8'd0; m_carry = 1'b0; m_out = 8'd0;
  endtask

  // pc has already been incremented once the fetch cycle is over
  task automatic compare();
    logic [3:0] epc;
    epc = (m_run && m_phase != 0) ? m_pc + 4'd1 : m_pc;
    chk("busy",   32'(bus.busy),     32'(m_run));
    chk("halted", 32'(bus.halted),   32'(m_halt));
    chk("acc",    32'(bus.acc),      32'(m_acc));
    chk("carry",  32'(bus.carry),    32'(m_carry));
    chk("out",    32'(bus.out_port), 32'(m_out));
    chk("pc",     32'(bus.pc),       32'(epc));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic do_reset();
    bus.start = 0; bus.load_en = 0;
    reset = 1'b1;
    model_reset();
    #1 compare();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    bus.load_en = 1; bus.load_addr = a; bus.load_data = d;
    tick();
    bus.load_en = 0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) load_word(4'(i), prog[i]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic do_start();
    bus.start = 1; tick(); bus.start = 0;
  endtask

  task automatic run_until_halt(input int maxc);
    int n = 0;
    while (m_run && n < maxc) begin tick(); n++; end
    if (n == maxc) chk("halt_timeout", 32'(n), 32'(0));
  endtask

  task automatic load_add_prog();
    clear_prog();
    prog[0] = 8'h83; prog[1] = 8'h3F; prog[2] = 8'hE0; prog[3] = 8'hF0; prog[15] = 8'h04;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0; bus.step = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    compare();
    reset = 1'b0;
    tick();

    // LDI 3 / ADD [F] / OUT / HLT
    load_add_prog(); load_prog();
    do_start();
    repeat (12) tick();
    chk("add_halted", 32'(bus.halted), 32'h1);
    chk("add_out",    32'(bus.out_port), 32'h07);
    chk("add_pc",     32'(bus.pc), 32'h4);
    chk("add_busy",   32'(bus.busy), 32'h0);

    // SUB borrow then JC
    clear_prog();
    prog[0] = 8'h80; prog[1] = 8'h4F; prog[2] = 8'hB6; prog[3] = 8'hF0;
    prog[6] = 8'hE0; prog[7] = 8'hF0; prog[15] = 8'h01;
    load_prog();
    do_start();
    repeat (9) tick();
    chk("sub_acc",   32'(bus.acc), 32'hFF);
    chk("sub_carry", 32'(bus.carry), 32'h1);
    chk("jc_pc",     32'(bus.pc), 32'h6);
    run_until_halt(50);
    chk("jc_out", 32'(bus.out_port), 32'hFF);

    // JMP 0 at top of memory: endless loop through the wrap
    clear_prog(); prog[15] = 8'h90;
    load_prog();
    do_start();
    repeat (100) tick();
    chk("loop_busy", 32'(bus.busy), 32'h1);
    do_reset();

    // reset during DECODE of ADD, then re-run from retained memory
    load_add_prog(); load_prog();
    do_start();
    repeat (4) tick();
    chk("pre_rst_acc", 32'(bus.acc), 32'h03);
    do_reset();
    chk("rst_acc", 32'(bus.acc), 32'h0);
    chk("rst_pc",  32'(bus.pc), 32'h0);
    do_start();
    repeat (12) tick();
    chk("rerun_out", 32'(bus.out_port), 32'h07);
    chk("rerun_halted", 32'(bus.halted), 32'h1);

    // load while busy is dropped, load while halted is applied
    clear_prog();
    prog[0] = 8'h85; prog[1] = 8'hE0; prog[2] = 8'hF0; prog[3] = 8'hE0; prog[4] = 8'hF0;
    load_prog();
    do_start();
    bus.load_en = 1; bus.load_addr = 4'h2; bus.load_data = 8'h8A;
    tick();
    bus.load_en = 0;
    run_until_halt(50);
    chk("busy_load_out", 32'(bus.out_port), 32'h05);
    chk("busy_load_pc",  32'(bus.pc), 32'h3);
    load_word(4'h2, 8'h8A);
    do_start();
    run_until_halt(50);
    chk("halt_load_out", 32'(bus.out_port), 32'h0A);
    chk("halt_load_pc",  32'(bus.pc), 32'h5);

    // randomized programs; the last word is loaded in the same cycle as start
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 15; i++) load_word(4'(i), 8'($urandom));
      bus.load_en = 1; bus.load_addr = 4'hF; bus.load_data = 8'($urandom); bus.start = 1;
      tick();
      bus.load_en = 0; bus.start = 0;
      for (int c = 0; c < int'($urandom_range(20, 80)); c++) begin
        bus.start   = ($urandom_range(0, 7) == 0);
        bus.load_en = ($urandom_range(0, 3) == 0);
        bus.load_addr = 4'($urandom);
        bus.load_data = 8'($urandom);
        bus.step    = 1'($urandom);
        tick();
      end
      bus.start = 0; bus.load_en = 0; bus.step = 0;
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clock); #2;
        reset = 1'b1;
        model_reset();
        #1 compare();
        @(negedge clock);
        reset = 1'b0;
      end else begin
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
